// File: rtl/acc_pkg.sv
// Shared opcode, flag and sizing definitions for the accumulator bank.
package acc_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP  = 3'b000,
      OP_LOAD = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_ADC  = 3'b100,
      OP_CLR  = 3'b101,
      OP_SHL  = 3'b110,
      OP_SHR  = 3'b111
   } acc_op_e;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
   } acc_flags_t;

   // A single channel still needs a one-bit select port.
   function automatic int sel_width(input int num_acc);
      return (num_acc > 1) ? $clog2(num_acc) : 1;
   endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational arithmetic for one accumulator channel: result plus zero/neg/carry/ovf.
module acc_alu
   import acc_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter bit SATURATE = 1'b0
) (
   input  logic [WIDTH-1:0] i_operand,
   input  logic [WIDTH-1:0] i_acc,
   input  logic             i_cin,
   input  acc_op_e          i_op,
   output logic [WIDTH-1:0] o_result,
   output acc_flags_t       o_flags
);

   localparam int MSB = WIDTH - 1;
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic             w_add_cin;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic             w_add_ovf;
   logic             w_sub_ovf;
   logic [WIDTH-1:0] w_raw;
   logic             w_carry;
   logic             w_ovf;

   assign w_add_cin = (i_op == OP_ADC) ? i_cin : 1'b0;
   assign w_sum     = {1'b0, i_acc} + {1'b0, i_operand} + {{WIDTH{1'b0}}, w_add_cin};
   assign w_diff    = {1'b0, i_acc} - {1'b0, i_operand};
   assign w_add_ovf = (i_acc[MSB] == i_operand[MSB]) && (w_sum[MSB] != i_acc[MSB]);
   assign w_sub_ovf = (i_acc[MSB] != i_operand[MSB]) && (w_diff[MSB] != i_acc[MSB]);

   always_comb begin
      w_raw   = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      case (i_op)
         OP_NOP: begin
            w_raw   = i_acc;
            w_carry = i_cin;
         end
         OP_LOAD: w_raw = i_operand;
         OP_ADD, OP_ADC: begin
            w_raw   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
            w_ovf   = w_add_ovf;
         end
         OP_SUB: begin
            w_raw   = w_diff[WIDTH-1:0];
            w_carry = w_diff[WIDTH];
            w_ovf   = w_sub_ovf;
         end
         OP_CLR: w_raw = '0;
         OP_SHL: begin
            w_raw   = {i_acc[MSB-1:0], 1'b0};
            w_carry = i_acc[MSB];
         end
         OP_SHR: begin
            w_raw   = {i_acc[MSB], i_acc[MSB:1]};
            w_carry = i_acc[0];
         end
         default: w_raw = i_acc;
      endcase
   end

   // Overflow direction follows the accumulator sign: it agrees with the true result's sign.
   assign o_result = (SATURATE && w_ovf) ? (i_acc[MSB] ? SAT_MIN : SAT_MAX) : w_raw;

   assign o_flags.zero  = (o_result == '0);
   assign o_flags.neg   = o_result[MSB];
   assign o_flags.carry = w_carry;
   assign o_flags.ovf   = w_ovf;

endmodule

// File: rtl/acc_bank.sv
// Bank of NUM_ACC accumulators with per-channel carry flags and a registered result port.
module acc_bank
   import acc_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int NUM_ACC  = 4,
   parameter bit SATURATE = 1'b0,
   localparam int SEL_W   = sel_width(NUM_ACC)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [OP_W-1:0]  op,
   input  logic [SEL_W-1:0] sel,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf,
   output logic             err
);

   // Handshake: en is a one-cycle request with no backpressure; every en sampled while
   // rst=0 yields exactly one out_valid pulse on the following cycle, flags valid with it.

   localparam logic [SEL_W:0] NUM_ACC_L = (SEL_W+1)'(NUM_ACC);

   logic [WIDTH-1:0] r_acc [NUM_ACC];
   logic [NUM_ACC-1:0] r_cflag;
   logic [WIDTH-1:0] r_out;
   acc_flags_t       r_flags;
   logic             r_err;
   logic             r_valid;

   logic             w_sel_ok;
   logic             w_wr;
   logic [WIDTH-1:0] w_acc_rd;
   logic             w_cin;
   logic [WIDTH-1:0] w_result;
   acc_flags_t       w_flags;

   assign w_sel_ok = ({1'b0, sel} < NUM_ACC_L);
   assign w_wr     = en && w_sel_ok;

   always_comb begin
      w_acc_rd = '0;
      w_cin    = 1'b0;
      for (int i = 0; i < NUM_ACC; i++) begin
         if (sel == SEL_W'(i)) begin
            w_acc_rd = r_acc[i];
            w_cin    = r_cflag[i];
         end
      end
   end

   acc_alu #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_alu (
      .i_operand (in),
      .i_acc     (w_acc_rd),
      .i_cin     (w_cin),
      .i_op      (acc_op_e'(op)),
      .o_result  (w_result),
      .o_flags   (w_flags)
   );

   // NOP writes back the same value and carry, so it needs no special case here.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ACC; i++) begin
            r_acc[i] <= '0;
         end
         r_cflag <= '0;
      end else if (w_wr) begin
         for (int i = 0; i < NUM_ACC; i++) begin
            if (sel == SEL_W'(i)) begin
               r_acc[i]   <= w_result;
               r_cflag[i] <= w_flags.carry;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out   <= '0;
         r_flags <= '0;
         r_err   <= 1'b0;
         r_valid <= 1'b0;
      end else if (en) begin
         r_valid <= 1'b1;
         if (w_sel_ok) begin
            r_out   <= w_result;
            r_flags <= w_flags;
            r_err   <= 1'b0;
         end else begin
            r_out   <= '0;
            r_flags <= '{zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0};
            r_err   <= 1'b1;
         end
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign out       = r_out;
   assign out_valid = r_valid;
   assign zero      = r_flags.zero;
   assign neg       = r_flags.neg;
   assign carry     = r_flags.carry;
   assign ovf       = r_flags.ovf;
   assign err       = r_err;

endmodule

// File: doc/acc_bank.md
ACC_BANK -- requirements
Module: acc_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning accumulator and data width in bits (>=4).
REQ-002 SHALL have parameter NUM_ACC, default 4, meaning number of independent accumulator channels (>=1).
REQ-003 SHALL have parameter SATURATE, default 0, meaning 1 = signed saturation on ADD/SUB/ADC overflow, 0 = two's-complement wrap.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock in the block.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 SHALL have port en  input  1  operation strobe; op, sel and in are sampled when en=1.
REQ-007 SHALL have port op  input  3  opcode: 000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 ADC, 101 CLR, 110 SHL, 111 SHR.
REQ-008 SHALL have port sel  input  max(1,clog2(NUM_ACC))  channel select.
REQ-009 SHALL have port in  input  WIDTH  operand.
REQ-010 SHALL have port out  output  WIDTH  registered result of the last operation.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse, high exactly one cycle after each accepted en.
REQ-012 SHALL have ports zero, neg, carry, ovf, err  output  1 each  registered flags for out, valid with out_valid.

Function
REQ-013 SHALL, on a rising edge with en=1 and rst=0, read acc[sel], compute the result, write it back to acc[sel], and present it on out at the next cycle (latency 1).
REQ-014 SHALL implement: LOAD acc=in; ADD acc+in; SUB acc-in; ADC acc+in+cflag[sel]; CLR acc=0; SHL logical left by 1; SHR arithmetic right by 1; NOP no change, out=acc[sel].
REQ-015 SHALL report carry as: ADD/ADC unsigned carry-out; SUB borrow (1 when in > acc unsigned); SHL bit shifted out (MSB); SHR bit shifted out (LSB); 0 for LOAD/CLR; previous cflag[sel] for NOP.
REQ-016 SHALL report ovf as signed overflow for ADD/SUB/ADC, 0 otherwise; zero = (out==0); neg = out[WIDTH-1].
REQ-017 SHALL, when SATURATE=1 and ovf=1, write and output 0x7F..F for positive overflow and 0x80..0 for negative overflow; carry and ovf still report the unsaturated result.
REQ-018 SHALL keep a per-channel carry flag cflag[i], updated with the carry of every operation on channel i except NOP.
REQ-019 SHALL, when sel >= NUM_ACC, modify no state, output out=0, err=1, out_valid=1; err=0 for every valid sel.
REQ-020 SHALL hold out and flags unchanged and drive out_valid=0 on any cycle after en=0.
REQ-021 SHALL apply back-to-back operations on the same channel without hazard: each uses the value written by the previous cycle.
REQ-022 SHALL leave all channels other than acc[sel] unchanged on every cycle.

Reset
REQ-023 SHALL, on rst=1 at a rising edge, clear all acc[i], all cflag[i], out, zero, neg, carry, ovf, err and out_valid to 0; zero resets to 0, not 1.
REQ-024 SHALL give rst priority over en: an operation presented with rst=1 is discarded and produces no out_valid.

Structure
REQ-025 SHALL place the opcode enumeration, flag-bundle type and opcode width constant in shared package acc_pkg.
REQ-026 SHALL implement arithmetic in one combinational sub-module acc_alu (operand, acc value, carry-in, op, SATURATE in; result and four flags out); acc_bank holds storage, select and output registers.

Verification
REQ-027 SHALL cover reset: rst=1 for 2 cycles after arbitrary traffic -> NOP on every channel returns out=0x0000, carry=0; out_valid low during reset.
REQ-028 SHALL cover overflow: ch0 LOAD 0x7FFF, ADD 0x0001 -> SATURATE=0: out=0x8000, ovf=1, neg=1, carry=0; SATURATE=1: out=0x7FFF, ovf=1.
REQ-029 SHALL cover carry chain: ch1 LOAD 0x0001, ADD 0xFFFF -> out=0x0000, zero=1, carry=1; ADC 0x0000 -> out=0x0001, carry=0; SUB 0x0002 -> out=0xFFFF, carry=1, neg=1.
REQ-030 SHALL cover isolation: ch2 LOAD 0x1234, ch3 LOAD 0x00FF, ch2 ADD 0x0001 three times back-to-back -> ch2 reads 0x1237, ch3 NOP reads 0x00FF.
REQ-031 SHALL cover shifts: LOAD 0x8002, SHR -> 0xC001, carry=0; LOAD 0x8001, SHL -> 0x0002, carry=1.
REQ-032 SHALL cover collision and range: rst=1 with en=1 LOAD 0xAAAA -> acc stays 0, no out_valid; with NUM_ACC=3, sel=3 LOAD 0x5555 -> err=1, out=0, channels 0-2 unchanged.
